// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM peripheral.
// Register map addresses, mode bit positions and the centre-mode direction states.
package pwm_pkg;
  localparam logic [5:0] ADDR_PRESCALE = 6'h20;
  localparam logic [5:0] ADDR_MODE     = 6'h21;

  localparam int MODE_CENTRE = 0;
  localparam int MODE_RUN    = 1;

  typedef enum logic {UP, DOWN} dir_t;
endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, edge/centre main counter and period-load generation.
// load is combinational on the wrapping tick; period_start is registered (1 cycle); no backpressure.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int RES        = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  centre,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  restart,
  output logic [RES-1:0]        cnt,
  output logic                  load,
  output logic                  period_start
);
  localparam logic [RES-1:0] MAX = '1;
  localparam logic [RES-1:0] ONE = RES'(1);

  logic [PRESCALE_W-1:0] pcnt, pcnt_nxt;
  logic [RES-1:0]        cnt_nxt;
  dir_t                  dir, dir_nxt;
  logic                  tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt         <= '0;
      cnt          <= '0;
      dir          <= UP;
      period_start <= 1'b0;
    end else begin
      pcnt         <= pcnt_nxt;
      cnt          <= cnt_nxt;
      dir          <= dir_nxt;
      period_start <= load | restart;
    end
  end

  always_comb begin
    pcnt_nxt = pcnt;
    cnt_nxt  = cnt;
    dir_nxt  = dir;
    tick     = 1'b0;
    load     = 1'b0;
    if (restart || !run) begin
      pcnt_nxt = '0;
      cnt_nxt  = '0;
      dir_nxt  = UP;
    end else begin
      tick     = (pcnt == prescale);
      pcnt_nxt = tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        if (!centre) begin
          cnt_nxt = cnt + 1'b1;
          load    = (cnt == MAX);
        end else begin
          unique case (dir)
            UP: begin
              if (cnt == MAX) begin
                cnt_nxt = MAX - 1'b1;
                dir_nxt = DOWN;
              end else begin
                cnt_nxt = cnt + 1'b1;
              end
            end
            DOWN: begin
              // Bottom of the triangle: return to 0 and reload, no repeated 0 tick.
              if (cnt <= ONE) begin
                cnt_nxt = '0;
                dir_nxt = UP;
                load    = 1'b1;
              end else begin
                cnt_nxt = cnt - 1'b1;
              end
            end
            default: dir_nxt = UP;
          endcase
        end
      end
    end
  end
endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: register decode, shadow/active duties, per-channel compare and gating.
// Write-to-register 1 cycle, cnt-to-out 1 cycle (registered); no backpressure.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int RES        = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [5:0]        wr_addr,
  input  logic [RES-1:0]    wr_data,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam logic [RES-1:0] MAX = '1;

  logic [RES-1:0]        duty_shd [NUM_CH];
  logic [RES-1:0]        duty_act [NUM_CH];
  logic [PRESCALE_W-1:0] prescale;
  logic [1:0]            mode;
  logic [RES-1:0]        cnt;
  logic                  load;
  logic                  restart;
  logic [NUM_CH-1:0]     out_nxt;

  assign restart = wr_valid && (wr_addr == ADDR_PRESCALE || wr_addr == ADDR_MODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      mode     <= '0;
    end else if (wr_valid) begin
      if (wr_addr == ADDR_PRESCALE) prescale <= wr_data[PRESCALE_W-1:0];
      if (wr_addr == ADDR_MODE)     mode     <= wr_data[1:0];
    end
  end

  // Active copy reads the old shadow, so a same-cycle duty write lands one period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_shd[i] <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (load || restart) duty_act[i] <= duty_shd[i];
        if (wr_valid && wr_addr == 6'(i)) duty_shd[i] <= wr_data;
      end
    end
  end

  pwm_timebase #(
    .RES       (RES),
    .PRESCALE_W(PRESCALE_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .run         (mode[MODE_RUN]),
    .centre      (mode[MODE_CENTRE]),
    .prescale    (prescale),
    .restart     (restart),
    .cnt         (cnt),
    .load        (load),
    .period_start(period_start)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic pwm;
    assign pwm        = (duty_act[g] == MAX) | (cnt < duty_act[g]);
    assign out_nxt[g] = en_out[g] ? (en_pwm[g] ? pwm : 1'b1) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= out_nxt;
  end
endmodule
